intbus_arbiter: RTL and testbench
=================================

# intbus_arbiter

Parametrised internal-bus arbiter and byte-lane steering unit that lets NUM_MASTERS bus masters share one 32-bit synchronous memory port. Typical masters are the 6502 external-bus bridge and video fetch engines. Downstream of the arbiter sit main RAM and the character ROM. It adds multi-master arbitration (round-robin or fixed priority), byte and 32-bit access sizes, and a latency-tracked read-return pipeline that routes each read response to the master that issued it.

## Interface
Parameters:
- NUM_MASTERS, 2: number of requesting masters (2..8).
- ADDR_W, 18: byte address width.
- RD_LATENCY, 1: memory read latency in cycles from mem_strobe to valid mem_rddata (1..4).
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (master 0 highest).

Ports (per-master vectors are flattened, master m occupies slice m):
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- m_req  in  NUM_MASTERS  request; held with fields stable until m_ack.
- m_write  in  NUM_MASTERS  1 = write, 0 = read.
- m_size  in  NUM_MASTERS  0 = byte, 1 = 32-bit word.
- m_addr  in  NUM_MASTERS*ADDR_W  byte address.
- m_wrdata  in  NUM_MASTERS*32  write data; byte writes use bits [7:0].
- m_ack  out  NUM_MASTERS  one-cycle, one-hot grant/accept.
- m_rdvalid  out  NUM_MASTERS  one-cycle read-data-valid pulse.
- m_rddata  out  32  read data, shared bus, qualified by m_rdvalid.
- mem_strobe  out  1  memory access this cycle.
- mem_write  out  1  write qualifier.
- mem_addr  out  ADDR_W-2  word address (byte address [ADDR_W-1:2]).
- mem_wrbytesel  out  4  byte enables.
- mem_wrdata  out  32  write data.
- mem_rddata  in  32  read data, valid RD_LATENCY cycles after the strobe.

## Operation
- Each cycle at most one master is granted among those with m_req=1. Grant is combinational in that cycle: m_ack[g]=1, mem_strobe=1, and mem_* fields are driven from master g.
- Round-robin: search starts at the master after last_grant, wrapping at NUM_MASTERS-1 to 0. last_grant updates only on a grant.
- Fixed priority: the lowest index wins; last_grant is unused.
- Byte access:
  - mem_wrbytesel is one-hot on addr[1:0] (00 gives 0001, 11 gives 1000).
  - mem_wrdata = 4 copies of wrdata[7:0].
- Word access:
  - addr[1:0] is ignored and the access is aligned down.
  - mem_wrbytesel = 1111 and mem_wrdata = wrdata.
- mem_wrbytesel is driven to 0000 on reads and when idle.
- Read tracking: a shift pipe of depth RD_LATENCY carries {valid, master id, size, addr[1:0]}.
  - When an entry exits the pipe, the arbiter registers m_rddata.
  - Word read: m_rddata = mem_rddata.
  - Byte read: m_rddata = {24'b0, selected byte}.
  - m_rdvalid[id] pulses in the same cycle m_rddata is registered.
- Writes produce no rdvalid.
- Reads from different masters may be back-to-back. Responses return in issue order.
- A master must not raise a new req until the rdvalid for its outstanding read has arrived. The arbiter does not check this.

## Timing
- Reset values: m_ack=0, m_rdvalid=0, m_rddata=0, mem_strobe=0, mem_write=0, mem_wrbytesel=0, mem_addr=0, mem_wrdata=0. The read pipe is cleared and last_grant=NUM_MASTERS-1, so master 0 wins first.
- Grant latency is 0 cycles: m_ack is asserted in the same cycle the request wins.
- Read response for a strobe in cycle N: m_rdvalid is asserted in cycle N+RD_LATENCY+1.
- Throughput: one access per cycle sustained. A single continuous requester is granted every cycle.
- Round-robin fairness: with all masters requesting, each master is granted exactly once per NUM_MASTERS cycles.
- Reset mid-operation: all in-flight reads are discarded, and no m_rdvalid is asserted after rst_n falls.
- When no master requests, outputs go idle (strobe=0, bytesel=0) and last_grant holds.

## Structure
- intbus_pkg holds:
  - SIZE_BYTE/SIZE_WORD constants.
  - ARB_RR/ARB_FIXED constants.
  - The read-pipe entry struct {valid, id, size, lane}.
  - The byte-select and byte-extract functions.
- Sub-module rr_arbiter (NUM parameter, MODE parameter): inputs req and last_grant; outputs one-hot grant and the encoded index. Purely combinational; the last_grant register lives in intbus_arbiter.
- The read pipe and output steering are implemented inline in intbus_arbiter.

## Test plan
- Byte write then byte read: master 0 writes 0xA5 to 0x00003 (bytesel 1000, wrdata 0xA5A5A5A5), then reads 0x00003. Expect m_rdvalid[0] at N+2 for RD_LATENCY=1 with m_rddata=0x000000A5.
- Word access: master 1 writes 0x11223344 to 0x00006. Expect mem_addr=1 and bytesel 1111. A subsequent word read returns 0x11223344, and a byte read of 0x00005 returns 0x00000033.
- Round-robin contention: NUM_MASTERS=3, all requesting continuously from reset. Expect grants 0,1,2,0,1,2 and no master granted twice within 3 cycles.
- Fixed priority: ARB_MODE=1 with masters 0 and 2 requesting. Master 0 is granted every cycle until it drops req; master 2 is granted in the next cycle.
- Latency sweep: RD_LATENCY=3, back-to-back reads from masters 0,1,0. Expect rdvalid pulses at N+4, N+5, N+6 with the correct id and data per read.
- Reset mid-flight: deassert rst_n one cycle after a read strobe. Expect all outputs 0 immediately, no rdvalid ever appears for that read, and master 0 is granted first after release.

Source files
------------

// File: rtl/intbus_pkg.sv
// Shared types, constants and lane helpers for the internal-bus arbiter.
package intbus_pkg;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Wide enough for the largest supported master count (8).
  localparam int ID_W = 3;

  // One slot of the read-return pipe.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            size;
    logic [1:0]      lane;
  } rd_entry_t;

  // One-hot byte enable for a byte access on the given lane.
  function automatic logic [3:0] byte_sel(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Pick the addressed byte out of a memory word.
  function automatic logic [7:0] byte_extract(input logic [31:0] data,
                                              input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/intbus_arbiter_rr.sv
// Combinational grant selection: round-robin after last_grant, or fixed
// priority with master 0 highest. Holds no state of its own.
module rr_arbiter
  import intbus_pkg::*;
#(
  parameter int NUM   = 2,
  parameter int MODE  = ARB_RR,
  parameter int IDX_W = 1
) (
  input  logic [NUM-1:0]   req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NUM-1:0]   grant,
  output logic [IDX_W-1:0] grant_idx
);

  int start;

  // Scan candidates in priority order from the start index, first requester wins.
  always_comb begin
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    start     = (MODE == ARB_FIXED) ? 0 : (int'(last_grant) + 1) % NUM;
    for (int k = 0; k < NUM; k++) begin
      for (int i = 0; i < NUM; i++) begin
        if (!found && req[i] && (i == (start + k) % NUM)) begin
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/intbus_arbiter.sv
// Multi-master arbiter for one 32-bit memory port with byte-lane steering
// and a latency-matched read-return pipe that routes data to the issuer.
module intbus_arbiter
  import intbus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 18,
  parameter int RD_LATENCY  = 1,
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS-1:0]        m_size,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*32-1:0]     m_wrdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_rdvalid,
  output logic [31:0]                   m_rddata,
  output logic                          mem_strobe,
  output logic                          mem_write,
  output logic [ADDR_W-3:0]             mem_addr,
  output logic [3:0]                    mem_wrbytesel,
  output logic [31:0]                   mem_wrdata,
  input  logic [31:0]                   mem_rddata
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] req_live;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       last_grant;
  logic                   any_grant;

  logic                   sel_write;
  logic                   sel_size;
  logic [ADDR_W-1:0]      sel_addr;
  logic [31:0]            sel_wrdata;

  rd_entry_t              issue_entry;
  rd_entry_t              rd_pipe [RD_LATENCY];
  rd_entry_t              pipe_out;

  // Requests are masked while in reset so the combinational grant path idles.
  assign req_live  = m_req & {NUM_MASTERS{rst_n}};
  assign any_grant = |grant;

  rr_arbiter #(
    .NUM   (NUM_MASTERS),
    .MODE  (ARB_MODE),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req_live),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Remember the most recent winner; idle cycles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_grant <= IDX_W'(NUM_MASTERS - 1);
    else if (any_grant) last_grant <= grant_idx;
  end

  // One-hot mux of the winning master's request fields (all zero when idle).
  always_comb begin
    sel_write  = 1'b0;
    sel_size   = 1'b0;
    sel_addr   = '0;
    sel_wrdata = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (grant[m]) begin
        sel_write  = m_write[m];
        sel_size   = m_size[m];
        sel_addr   = m_addr[m*ADDR_W +: ADDR_W];
        sel_wrdata = m_wrdata[m*32 +: 32];
      end
    end
  end

  // Drive the memory port and build the tracking entry for this cycle's access.
  always_comb begin
    m_ack         = grant;
    mem_strobe    = any_grant;
    mem_write     = any_grant & sel_write;
    mem_addr      = sel_addr[ADDR_W-1:2];
    mem_wrbytesel = 4'b0000;
    mem_wrdata    = '0;
    if (any_grant) begin
      if (sel_size == SIZE_WORD) begin
        mem_wrdata = sel_wrdata;
        if (sel_write) mem_wrbytesel = 4'b1111;
      end else begin
        mem_wrdata = {4{sel_wrdata[7:0]}};
        if (sel_write) mem_wrbytesel = byte_sel(sel_addr[1:0]);
      end
    end
    issue_entry.valid = any_grant & ~sel_write;
    issue_entry.id    = ID_W'(grant_idx);
    issue_entry.size  = sel_size;
    issue_entry.lane  = sel_addr[1:0];
  end

  // Read-tracking shift pipe, one stage per cycle of memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LATENCY; s++) rd_pipe[s] <= '0;
    end else begin
      rd_pipe[0] <= issue_entry;
      for (int s = 1; s < RD_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
  end

  assign pipe_out = rd_pipe[RD_LATENCY-1];

  // Return stage: capture memory data as the matching entry leaves the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdvalid <= '0;
      m_rddata  <= '0;
    end else begin
      m_rdvalid <= pipe_out.valid ? (NUM_MASTERS'(1) << pipe_out.id) : '0;
      if (pipe_out.valid) begin
        if (pipe_out.size == SIZE_WORD) m_rddata <= mem_rddata;
        else                            m_rddata <= {24'b0, byte_extract(mem_rddata, pipe_out.lane)};
      end
    end
  end

endmodule

// File: tb/tb_intbus_arbiter.sv
// Directed bench: instance A is 3-master round-robin with 1-cycle memory,
// instance B is 3-master fixed priority with 3-cycle memory.
module tb_intbus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [2:0]  a_req, a_write, a_size, a_ack, a_rdvalid;
  logic [53:0] a_addr;
  logic [95:0] a_wrdata;
  logic [31:0] a_rddata, a_mem_wrdata, a_mem_rddata;
  logic        a_strobe, a_mem_write;
  logic [15:0] a_mem_addr;
  logic [3:0]  a_sel;

  logic [2:0]  b_req, b_write, b_size, b_ack, b_rdvalid;
  logic [53:0] b_addr;
  logic [95:0] b_wrdata;
  logic [31:0] b_rddata, b_mem_wrdata, b_mem_rddata;
  logic        b_strobe, b_mem_write;
  logic [15:0] b_mem_addr;
  logic [3:0]  b_sel;

  logic [31:0] amem [64];
  logic [31:0] bmem [64];
  logic [31:0] a_rd1, b_rd1, b_rd2, b_rd3;

  intbus_arbiter #(.NUM_MASTERS(3), .ADDR_W(18), .RD_LATENCY(1), .ARB_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .m_req(a_req), .m_write(a_write), .m_size(a_size),
    .m_addr(a_addr), .m_wrdata(a_wrdata), .m_ack(a_ack), .m_rdvalid(a_rdvalid),
    .m_rddata(a_rddata), .mem_strobe(a_strobe), .mem_write(a_mem_write),
    .mem_addr(a_mem_addr), .mem_wrbytesel(a_sel), .mem_wrdata(a_mem_wrdata),
    .mem_rddata(a_mem_rddata));

  intbus_arbiter #(.NUM_MASTERS(3), .ADDR_W(18), .RD_LATENCY(3), .ARB_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .m_req(b_req), .m_write(b_write), .m_size(b_size),
    .m_addr(b_addr), .m_wrdata(b_wrdata), .m_ack(b_ack), .m_rdvalid(b_rdvalid),
    .m_rddata(b_rddata), .mem_strobe(b_strobe), .mem_write(b_mem_write),
    .mem_addr(b_mem_addr), .mem_wrbytesel(b_sel), .mem_wrdata(b_mem_wrdata),
    .mem_rddata(b_mem_rddata));

  // Behavioural memories: byte-enabled writes, fixed read latency.
  initial begin
    for (int i = 0; i < 64; i++) begin
      amem[i] = 32'h0;
      bmem[i] = 32'hA0B0C0D0 + 32'h01010101 * i;
    end
  end

  always @(posedge clk) begin
    if (a_strobe && a_mem_write)
      for (int i = 0; i < 4; i++) if (a_sel[i]) amem[a_mem_addr[5:0]][8*i +: 8] <= a_mem_wrdata[8*i +: 8];
    a_rd1 <= amem[a_mem_addr[5:0]];
  end
  assign a_mem_rddata = a_rd1;

  always @(posedge clk) begin
    if (b_strobe && b_mem_write)
      for (int i = 0; i < 4; i++) if (b_sel[i]) bmem[b_mem_addr[5:0]][8*i +: 8] <= b_mem_wrdata[8*i +: 8];
    b_rd1 <= bmem[b_mem_addr[5:0]];
    b_rd2 <= b_rd1;
    b_rd3 <= b_rd2;
  end
  assign b_mem_rddata = b_rd3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input int m, input logic wr, input logic sz,
                       input logic [17:0] ad, input logic [31:0] d);
    a_write[m] = wr;
    a_size[m]  = sz;
    a_addr[m*18 +: 18]   = ad;
    a_wrdata[m*32 +: 32] = d;
  endtask

  task automatic b_set(input int m, input logic wr, input logic sz,
                       input logic [17:0] ad, input logic [31:0] d);
    b_write[m] = wr;
    b_size[m]  = sz;
    b_addr[m*18 +: 18]   = ad;
    b_wrdata[m*32 +: 32] = d;
  endtask

  task automatic test_reset();
    a_set(0, 1'b1, 1'b1, 18'h4, 32'hDEADBEEF);
    a_req = 3'b111;
    b_req = 3'b111;
    @(negedge clk);
    checks++; if (a_ack !== 3'b000) begin errors++; $display("FAIL rst_a_ack got %b exp 000", a_ack); end
    checks++; if (a_strobe !== 1'b0) begin errors++; $display("FAIL rst_a_strobe got %b exp 0", a_strobe); end
    checks++; if (a_mem_write !== 1'b0) begin errors++; $display("FAIL rst_a_write got %b exp 0", a_mem_write); end
    checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL rst_a_sel got %b exp 0000", a_sel); end
    checks++; if (a_mem_addr !== 16'h0) begin errors++; $display("FAIL rst_a_addr got %h exp 0000", a_mem_addr); end
    checks++; if (a_mem_wrdata !== 32'h0) begin errors++; $display("FAIL rst_a_wrdata got %h exp 00000000", a_mem_wrdata); end
    checks++; if (a_rdvalid !== 3'b000) begin errors++; $display("FAIL rst_a_rdvalid got %b exp 000", a_rdvalid); end
    checks++; if (a_rddata !== 32'h0) begin errors++; $display("FAIL rst_a_rddata got %h exp 00000000", a_rddata); end
    checks++; if (b_ack !== 3'b000) begin errors++; $display("FAIL rst_b_ack got %b exp 000", b_ack); end
    checks++; if (b_strobe !== 1'b0) begin errors++; $display("FAIL rst_b_strobe got %b exp 0", b_strobe); end
    checks++; if (b_rdvalid !== 3'b000) begin errors++; $display("FAIL rst_b_rdvalid got %b exp 000", b_rdvalid); end
    a_req = 3'b000;
    b_req = 3'b000;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_byte_rw();
    a_set(0, 1'b1, 1'b0, 18'h00003, 32'h123456A5);
    a_req = 3'b001;
    @(negedge clk);
    checks++; if (a_ack !== 3'b001) begin errors++; $display("FAIL bw_ack got %b exp 001", a_ack); end
    checks++; if (a_mem_write !== 1'b1 || a_strobe !== 1'b1) begin errors++; $display("FAIL bw_strobe got %b%b exp 11", a_strobe, a_mem_write); end
    checks++; if (a_sel !== 4'b1000) begin errors++; $display("FAIL bw_sel got %b exp 1000", a_sel); end
    checks++; if (a_mem_wrdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL bw_wrdata got %h exp A5A5A5A5", a_mem_wrdata); end
    checks++; if (a_mem_addr !== 16'h0) begin errors++; $display("FAIL bw_addr got %h exp 0000", a_mem_addr); end
    step();
    a_set(0, 1'b0, 1'b0, 18'h00003, 32'h0);
    @(negedge clk);
    checks++; if (a_ack !== 3'b001) begin errors++; $display("FAIL br_ack got %b exp 001", a_ack); end
    checks++; if (a_sel !== 4'b0000 || a_mem_write !== 1'b0) begin errors++; $display("FAIL br_sel got %b/%b exp 0000/0", a_sel, a_mem_write); end
    step();
    a_req = 3'b000;
    @(negedge clk);
    checks++; if (a_rdvalid !== 3'b000) begin errors++; $display("FAIL br_early got %b exp 000", a_rdvalid); end
    checks++; if (a_strobe !== 1'b0 || a_sel !== 4'b0000) begin errors++; $display("FAIL idle_out got %b/%b exp 0/0000", a_strobe, a_sel); end
    step();
    @(negedge clk);
    checks++; if (a_rdvalid !== 3'b001) begin errors++; $display("FAIL br_rdvalid got %b exp 001", a_rdvalid); end
    checks++; if (a_rddata !== 32'h000000A5) begin errors++; $display("FAIL br_rddata got %h exp 000000A5", a_rddata); end
    step();
    @(negedge clk);
    checks++; if (a_rdvalid !== 3'b000) begin errors++; $display("FAIL br_pulse got %b exp 000", a_rdvalid); end
    step();
  endtask

  task automatic test_word();
    a_set(1, 1'b1, 1'b1, 18'h00006, 32'h11223344);
    a_req = 3'b010;
    @(negedge clk);
    checks++; if (a_ack !== 3'b010) begin errors++; $display("FAIL ww_ack got %b exp 010", a_ack); end
    checks++; if (a_mem_addr !== 16'h1) begin errors++; $display("FAIL ww_addr got %h exp 0001", a_mem_addr); end
    checks++; if (a_sel !== 4'b1111) begin errors++; $display("FAIL ww_sel got %b exp 1111", a_sel); end
    checks++; if (a_mem_wrdata !== 32'h11223344) begin errors++; $display("FAIL ww_wrdata got %h exp 11223344", a_mem_wrdata); end
    step();
    a_set(1, 1'b0, 1'b1, 18'h00006, 32'h0);
    step();
    a_req = 3'b000;
    step();
    @(negedge clk);
    checks++; if (a_rdvalid !== 3'b010) begin errors++; $display("FAIL wr_rdvalid got %b exp 010", a_rdvalid); end
    checks++; if (a_rddata !== 32'h11223344) begin errors++; $display("FAIL wr_rddata got %h exp 11223344", a_rddata); end
    step();
    a_set(1, 1'b0, 1'b0, 18'h00005, 32'h0);
    a_req = 3'b010;
    step();
    a_req = 3'b000;
    step();
    @(negedge clk);
    checks++; if (a_rdvalid !== 3'b010) begin errors++; $display("FAIL wb_rdvalid got %b exp 010", a_rdvalid); end
    checks++; if (a_rddata !== 32'h00000033) begin errors++; $display("FAIL wb_rddata got %h exp 00000033", a_rddata); end
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ack;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int m = 0; m < 3; m++) a_set(m, 1'b1, 1'b1, 18'(32 + 4*m), 32'h5000 + m);
    a_req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_ack = 3'b001 << (c % 3);
      @(negedge clk);
      checks++; if (a_ack !== exp_ack) begin errors++; $display("FAIL rr_cycle%0d got %b exp %b", c, a_ack, exp_ack); end
      step();
    end
    a_req = 3'b000;
    @(negedge clk);
    checks++; if (a_strobe !== 1'b0 || a_sel !== 4'b0000) begin errors++; $display("FAIL rr_idle got %b/%b exp 0/0000", a_strobe, a_sel); end
    step();
    a_req = 3'b101;
    @(negedge clk);
    checks++; if (a_ack !== 3'b001) begin errors++; $display("FAIL rr_hold got %b exp 001", a_ack); end
    step();
    a_req = 3'b100;
    @(negedge clk);
    checks++; if (a_ack !== 3'b100) begin errors++; $display("FAIL rr_next got %b exp 100", a_ack); end
    step();
    a_req = 3'b000;
  endtask

  task automatic test_fixed();
    b_set(0, 1'b1, 1'b1, 18'h00000, 32'hCAFE0000);
    b_set(2, 1'b1, 1'b1, 18'h00030, 32'hCAFE0002);
    b_req = 3'b101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (b_ack !== 3'b001) begin errors++; $display("FAIL fx_m0_cycle%0d got %b exp 001", c, b_ack); end
      step();
    end
    b_req = 3'b100;
    @(negedge clk);
    checks++; if (b_ack !== 3'b100) begin errors++; $display("FAIL fx_m2 got %b exp 100", b_ack); end
    step();
    b_req = 3'b101;
    @(negedge clk);
    checks++; if (b_ack !== 3'b001) begin errors++; $display("FAIL fx_m0_back got %b exp 001", b_ack); end
    step();
    b_req = 3'b000;
  endtask

  task automatic test_latency();
    b_set(0, 1'b0, 1'b1, 18'h00010, 32'h0);
    b_req = 3'b001;
    @(negedge clk);
    checks++; if (b_ack !== 3'b001) begin errors++; $display("FAIL lat_ack0 got %b exp 001", b_ack); end
    step();
    b_set(1, 1'b0, 1'b0, 18'h00015, 32'h0);
    b_req = 3'b010;
    @(negedge clk);
    checks++; if (b_ack !== 3'b010) begin errors++; $display("FAIL lat_ack1 got %b exp 010", b_ack); end
    step();
    b_set(0, 1'b0, 1'b1, 18'h00020, 32'h0);
    b_req = 3'b001;
    step();
    b_req = 3'b000;
    @(negedge clk);
    checks++; if (b_rdvalid !== 3'b000) begin errors++; $display("FAIL lat_early got %b exp 000", b_rdvalid); end
    step();
    @(negedge clk);
    checks++; if (b_rdvalid !== 3'b001 || b_rddata !== 32'hA4B4C4D4) begin errors++; $display("FAIL lat_r0 got %b/%h exp 001/A4B4C4D4", b_rdvalid, b_rddata); end
    step();
    @(negedge clk);
    checks++; if (b_rdvalid !== 3'b010 || b_rddata !== 32'h000000C5) begin errors++; $display("FAIL lat_r1 got %b/%h exp 010/000000C5", b_rdvalid, b_rddata); end
    step();
    @(negedge clk);
    checks++; if (b_rdvalid !== 3'b001 || b_rddata !== 32'hA8B8C8D8) begin errors++; $display("FAIL lat_r2 got %b/%h exp 001/A8B8C8D8", b_rdvalid, b_rddata); end
    step();
    @(negedge clk);
    checks++; if (b_rdvalid !== 3'b000) begin errors++; $display("FAIL lat_tail got %b exp 000", b_rdvalid); end
    step();
  endtask

  task automatic test_reset_midflight();
    a_set(1, 1'b0, 1'b1, 18'h00006, 32'h0);
    a_req = 3'b010;
    @(negedge clk);
    checks++; if (a_ack !== 3'b010) begin errors++; $display("FAIL mf_ack got %b exp 010", a_ack); end
    step();
    for (int m = 0; m < 3; m++) a_set(m, 1'b1, 1'b1, 18'(48 + 4*m), 32'h7000 + m);
    a_req = 3'b111;
    rst_n = 1'b0;
    #1;
    checks++; if (a_ack !== 3'b000 || a_strobe !== 1'b0 || a_sel !== 4'b0000) begin errors++; $display("FAIL mf_outs got %b/%b/%b exp 000/0/0000", a_ack, a_strobe, a_sel); end
    @(negedge clk);
    checks++; if (a_rdvalid !== 3'b000) begin errors++; $display("FAIL mf_rdv0 got %b exp 000", a_rdvalid); end
    step();
    @(negedge clk);
    checks++; if (a_rdvalid !== 3'b000) begin errors++; $display("FAIL mf_rdv1 got %b exp 000", a_rdvalid); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_ack !== 3'b001) begin errors++; $display("FAIL mf_first got %b exp 001", a_ack); end
    checks++; if (a_rdvalid !== 3'b000) begin errors++; $display("FAIL mf_rdv2 got %b exp 000", a_rdvalid); end
    step();
    a_req = 3'b000;
    @(negedge clk);
    checks++; if (a_rdvalid !== 3'b000) begin errors++; $display("FAIL mf_rdv3 got %b exp 000", a_rdvalid); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    a_req    = '0; a_write = '0; a_size = '0; a_addr = '0; a_wrdata = '0;
    b_req    = '0; b_write = '0; b_size = '0; b_addr = '0; b_wrdata = '0;
    test_reset();
    test_byte_rw();
    test_word();
    test_round_robin();
    test_fixed();
    test_latency();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
